// File: rtl/alu_n_bit_seq_if.sv
// ---------------------------------------------------------------------------
// alu_n_bit_seq_if
// Request/response bundle between the register-read stage, the sequential
// ALU and writeback.
//   Request  : in_valid, in_ready, ALUOp, a, b, CarryIn
//   Response : out_valid, out_ready, Result, ResultHi, CarryOut, Zero, Overflow
// master : the side that issues operations and consumes results
// slave  : the ALU itself
// ---------------------------------------------------------------------------
interface alu_n_bit_seq_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             CarryIn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] ResultHi;
  logic             CarryOut;
  logic             Zero;
  logic             Overflow;

  modport master (
    output in_valid, ALUOp, a, b, CarryIn, out_ready,
    input  in_ready, out_valid, Result, ResultHi, CarryOut, Zero, Overflow
  );

  modport slave (
    input  in_valid, ALUOp, a, b, CarryIn, out_ready,
    output in_ready, out_valid, Result, ResultHi, CarryOut, Zero, Overflow
  );
endinterface

// File: rtl/alu_n_bit_seq.sv
// ---------------------------------------------------------------------------
// alu_n_bit_seq
// Handshaked N-bit ALU with registered results. Logic, add/sub and
// set-less-than complete in one cycle; MUL is an unsigned shift-add
// multiplier taking WIDTH cycles and producing a 2*WIDTH-bit product.
// Only one operation is ever in flight.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_n_bit_seq_if.slave (request handshake, operands, opcode,
//           response handshake, Result/ResultHi and CarryOut/Zero/Overflow)
// ---------------------------------------------------------------------------
module alu_n_bit_seq #(
  parameter int WIDTH = 6
) (
  input  logic           clk,
  input  logic           reset,
  alu_n_bit_seq_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Multiplier datapath
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;

  // Result registers driving the response side
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_carry;
  logic               r_zero;
  logic               r_ovf;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic [WIDTH:0]     w_sum_add;
  logic [WIDTH:0]     w_sum_sub;
  logic               w_ovf_add;
  logic               w_ovf_sub;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_cout;
  logic               w_alu_ovf;
  logic               w_alu_zero;
  logic [WIDTH:0]     w_mul_upper;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last_step;

  // Two's-complement overflow: addends agree in sign, the sum disagrees.
  function automatic logic f_signed_ovf(input logic sign_x, input logic sign_y,
                                        input logic sign_sum);
    f_signed_ovf = (sign_x == sign_y) && (sign_sum != sign_x);
  endfunction

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.ALUOp == OP_MUL);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.Result    = r_result;
  assign bus.ResultHi  = r_result_hi;
  assign bus.CarryOut  = r_carry;
  assign bus.Zero      = r_zero;
  assign bus.Overflow  = r_ovf;

  // Single-cycle ALU evaluated on the request operands.
  always_comb begin
    w_sum_add  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.CarryIn};
    w_sum_sub  = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    w_ovf_add  = f_signed_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], w_sum_add[WIDTH-1]);
    w_ovf_sub  = f_signed_ovf(bus.a[WIDTH-1], ~bus.b[WIDTH-1], w_sum_sub[WIDTH-1]);
    w_alu_res  = {WIDTH{1'b0}};
    w_alu_cout = 1'b0;
    w_alu_ovf  = 1'b0;
    case (bus.ALUOp)
      OP_AND: w_alu_res = bus.a & bus.b;
      OP_OR:  w_alu_res = bus.a | bus.b;
      OP_NOR: w_alu_res = ~(bus.a | bus.b);
      OP_ADD: begin
        w_alu_res  = w_sum_add[WIDTH-1:0];
        w_alu_cout = w_sum_add[WIDTH];
        w_alu_ovf  = w_ovf_add;
      end
      OP_SUB: begin
        w_alu_res  = w_sum_sub[WIDTH-1:0];
        w_alu_cout = w_sum_sub[WIDTH];
        w_alu_ovf  = w_ovf_sub;
      end
      // Sign of the difference corrected by overflow gives the true signed compare.
      OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_sum_sub[WIDTH-1] ^ w_ovf_sub};
      default: w_alu_res = {WIDTH{1'b0}};
    endcase
    w_alu_zero = (w_alu_res == {WIDTH{1'b0}});
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half (keeping its carry), then shift the whole accumulator right by one.
  always_comb begin
    if (r_mplier[0]) begin
      w_mul_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    end else begin
      w_mul_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    end
    w_acc_next  = (2*WIDTH)'({w_mul_upper, r_acc[WIDTH-1:0]} >> 1);
    w_last_step = (r_cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; DONE with out_ready behaves like IDLE for a new request.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? S_BUSY : S_DONE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_last_step) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_BUSY;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? S_BUSY : S_DONE;
        end else if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath registers: capture on accept, iterate while multiplying.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= {CW{1'b0}};
      r_mcand     <= {WIDTH{1'b0}};
      r_mplier    <= {WIDTH{1'b0}};
      r_acc       <= {(2*WIDTH){1'b0}};
      r_result    <= {WIDTH{1'b0}};
      r_result_hi <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand  <= bus.a;
        r_mplier <= bus.b;
        r_acc    <= {(2*WIDTH){1'b0}};
        r_cnt    <= {CW{1'b0}};
      end else begin
        r_result    <= w_alu_res;
        r_result_hi <= {WIDTH{1'b0}};
        r_carry     <= w_alu_cout;
        r_zero      <= w_alu_zero;
        r_ovf       <= w_alu_ovf;
      end
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_next;
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + CW'(1);
      if (w_last_step) begin
        // Final step publishes the product straight from the step result.
        r_result    <= w_acc_next[WIDTH-1:0];
        r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
        r_carry     <= 1'b0;
        r_ovf       <= 1'b0;
        r_zero      <= (w_acc_next == {(2*WIDTH){1'b0}});
      end else begin
        r_result <= r_result;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: doc/alu_n_bit_seq.md
# alu_n_bit_seq

Parametrised, handshaked successor to the 6-bit combinational ALU. It keeps the same ALUOp encoding and adds the following:
- generic operand width;
- registered outputs with valid/ready flow control;
- set-less-than;
- Zero and Overflow flags;
- a multicycle unsigned shift-add multiplier that produces a double-width product.

It sits between the register-read stage and writeback, and accepts at most one operation in flight.

## Interface
- WIDTH, 6, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request present
- in_ready  output  1  block can accept a request this cycle
- ALUOp  input  4  operation code, sampled on accept
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- CarryIn  input  1  carry into ADD, sampled on accept
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- Result  output  WIDTH  result; for MUL, the low WIDTH bits of the product
- ResultHi  output  WIDTH  high WIDTH bits of the MUL product; 0 for all other ops
- CarryOut  output  1  carry out (ADD/SUB only, otherwise 0)
- Zero  output  1  1 when Result (and ResultHi for MUL) is all zero
- Overflow  output  1  signed overflow (ADD/SUB only, otherwise 0)

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 1100 NOR: bitwise.
  - 0010 ADD: a + b + CarryIn.
  - 0110 SUB: a + ~b + 1, with CarryIn ignored.
  - 0111 SLT: Result = 1 if signed a < signed b, else 0. Computed from the SUB sign XOR the SUB overflow.
  - 0011 MUL: unsigned a × b, giving a 2·WIDTH-bit product split as {ResultHi, Result}.
  - Any other code: Result = 0, ResultHi = 0, CarryOut = 0, Overflow = 0, Zero = 1.
- Arithmetic:
  - CarryOut is bit WIDTH of the (WIDTH+1)-bit sum.
  - Overflow = (sign a == sign of second addend) && (sign result != sign a). The second addend is b for ADD and ~b for SUB.
  - All other arithmetic wraps modulo 2^WIDTH.
- FSM states:
  - IDLE: no result held.
  - BUSY: multiplying; a log2(WIDTH)-bit counter `cnt`, multiplicand register, multiplier shift register, and 2·WIDTH accumulator are active.
  - DONE: result held.
- Accept: in_valid && in_ready at a rising edge.
- Transitions:
  - IDLE → DONE on accept of a non-MUL op. Result and flags are registered at that edge.
  - IDLE → BUSY on accept of MUL. Operands are loaded, the accumulator and `cnt` are cleared.
  - BUSY, each edge: if multiplier bit 0 is set, add the multiplicand to the accumulator's upper half, then shift right one; `cnt`++. On the edge where `cnt` == WIDTH−1, write {ResultHi, Result} and the flags, and go to DONE.
  - DONE → IDLE when out_ready && !in_valid.
  - DONE → DONE / BUSY when out_ready && in_valid, i.e. back-to-back accept: the new op is handled exactly as from IDLE.
  - DONE holds when !out_ready.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is combinational from out_ready; no other combinational input-to-output paths exist.
- out_valid = (state == DONE).

## Timing
- Reset (asynchronous, any time, including mid-MUL):
  - state = IDLE, cnt = 0;
  - Result, ResultHi, CarryOut, Zero, Overflow, out_valid all 0;
  - in_ready = 1 once in IDLE.
- No request is accepted while reset is high.
- Non-MUL latency is 1 cycle: out_valid is high in the cycle after the accept edge.
- MUL latency is WIDTH cycles: out_valid rises after the WIDTH-th edge following the accept edge. in_ready = 0 throughout BUSY.
- Throughput for non-MUL ops is 1 per cycle when out_ready is held high.
- While out_valid && !out_ready, all result outputs and flags are held stable, and inputs are ignored.
- in_valid may drop without acceptance; no state is captured without an accept.

## Test plan
All scenarios use WIDTH = 6.
- **Reset:** assert reset for 2 cycles, with and without a prior accept.
  - Required: all outputs 0, out_valid 0, in_ready 1.
  - Also: reset asserted 3 cycles into a MUL returns to IDLE, and no result appears afterwards.
- **Logic ops:** a = 1, b = 2.
  - AND → Result 0, Zero 1.
  - OR → Result 3, Zero 0.
  - NOR → Result 60.
  - Each gives out_valid 1 cycle after accept.
- **ADD:**
  - 63 + 1, CarryIn 0 → Result 0, CarryOut 1, Zero 1, Overflow 0.
  - 31 + 1 → Result 32, Overflow 1, CarryOut 0.
  - 1 + 2, CarryIn 1 → Result 4.
- **SUB / SLT:**
  - SUB 1 − 2 → Result 63, CarryOut 0.
  - SUB 2 − 2 → Result 0, CarryOut 1, Zero 1.
  - SLT(1, 2) → 1.
  - SLT(62, 1) → 1, since 62 is −2 signed.
  - SLT(1, 62) → 0.
- **MUL:** 63 × 63.
  - in_ready 0 for 6 cycles; out_valid after 6 edges.
  - ResultHi 62, Result 1, Zero 0, CarryOut 0, Overflow 0.
  - 0 × 45 → ResultHi 0, Result 0, Zero 1.
- **Flow control:**
  - Hold out_ready low for 3 cycles while DONE: outputs stay constant and in_ready stays 0.
  - Then issue ADD, OR, SUB back-to-back with out_ready high: one result per cycle, in order.
  - Illegal opcode 1111 → Result 0, Zero 1.
